// File: rtl/c3aibadapt_txasync_pkg.sv
// rtl/c3aibadapt_txasync_pkg.sv - shared defaults for the TX adapter async sideband filter
package c3aibadapt_txasync_pkg;

   // Default synchroniser depth; two flops is the minimum for metastability settling.
   localparam int SYNC_STAGES_DEF = 2;

   // Default debounce counter / threshold width.
   localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/c3aibadapt_txasync_filt_ch.sv
// rtl/c3aibadapt_txasync_filt_ch.sv - one channel: synchroniser, debounce, change pulse and sticky flag
module c3aibadapt_txasync_filt_ch
   import c3aibadapt_txasync_pkg::*;
#(
   parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int   CNT_W       = CNT_W_DEF,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic             osc_clk,
   input  logic             osc_rst,
   input  logic             async_in,
   input  logic [CNT_W-1:0] r_filt_thresh,
   input  logic             r_bypass,
   input  logic             sticky_clr,
   output logic             filt_out,
   output logic             chg_pulse,
   output logic             chg_sticky
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_q;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic                   filt_next;
   logic                   pulse_next;

   // Plain flop chain; resets to the channel's idle level so release creates no edge.
   always_ff @(posedge osc_clk) begin
      if (osc_rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      end
   end

   assign s_q = sync_q[SYNC_STAGES-1];

   // Debounce decision: commit once s_q has differed for more than T cycles, or at once in bypass.
   always_comb begin
      filt_next  = filt_out;
      cnt_next   = cnt;
      pulse_next = 1'b0;
      if (r_bypass) begin
         filt_next  = s_q;
         cnt_next   = '0;
         pulse_next = (s_q != filt_out);
      end else if (s_q == filt_out) begin
         cnt_next = '0;
      end else if (cnt >= r_filt_thresh) begin
         // >= so a threshold lowered below the running count commits immediately
         filt_next  = s_q;
         cnt_next   = '0;
         pulse_next = 1'b1;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Output, counter and event registers; sticky follows the registered pulse and set beats clear.
   always_ff @(posedge osc_clk) begin
      if (osc_rst) begin
         filt_out   <= RST_VAL;
         cnt        <= '0;
         chg_pulse  <= 1'b0;
         chg_sticky <= 1'b0;
      end else begin
         filt_out   <= filt_next;
         cnt        <= cnt_next;
         chg_pulse  <= pulse_next;
         chg_sticky <= (chg_sticky & ~sticky_clr) | chg_pulse;
      end
   end

endmodule

// File: rtl/c3aibadapt_txasync_filter.sv
// rtl/c3aibadapt_txasync_filter.sv - multi-channel async sideband sync and debounce for the TX adapter
module c3aibadapt_txasync_filter
   import c3aibadapt_txasync_pkg::*;
#(
   parameter int                NUM_CH      = 2,
   parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int                CNT_W       = CNT_W_DEF,
   parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
   input  logic              osc_clk,
   input  logic              osc_rst,
   input  logic [NUM_CH-1:0] async_in,
   input  logic [CNT_W-1:0]  r_filt_thresh,
   input  logic [NUM_CH-1:0] r_bypass,
   input  logic [NUM_CH-1:0] sticky_clr,
   output logic [NUM_CH-1:0] filt_out,
   output logic [NUM_CH-1:0] chg_pulse,
   output logic [NUM_CH-1:0] chg_sticky
);

   // Channels are fully independent; only the threshold is shared.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      c3aibadapt_txasync_filt_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W),
         .RST_VAL     (RST_VAL[i])
      ) u_ch (
         .osc_clk       (osc_clk),
         .osc_rst       (osc_rst),
         .async_in      (async_in[i]),
         .r_filt_thresh (r_filt_thresh),
         .r_bypass      (r_bypass[i]),
         .sticky_clr    (sticky_clr[i]),
         .filt_out      (filt_out[i]),
         .chg_pulse     (chg_pulse[i]),
         .chg_sticky    (chg_sticky[i])
      );
   end

endmodule

// File: tb/tb_c3aibadapt_txasync_filter.sv
// tb/tb_c3aibadapt_txasync_filter.sv - directed vector bench for the async sideband filter
module tb_c3aibadapt_txasync_filter;

   localparam int         NUM_CH      = 2;
   localparam int         SYNC_STAGES = 2;
   localparam int         CNT_W       = 4;
   localparam logic [1:0] RST_VAL     = 2'b10;

   logic             osc_clk = 1'b0;
   logic             osc_rst;
   logic [1:0]       async_in;
   logic [CNT_W-1:0] r_filt_thresh;
   logic [1:0]       r_bypass;
   logic [1:0]       sticky_clr;
   logic [1:0]       filt_out;
   logic [1:0]       chg_pulse;
   logic [1:0]       chg_sticky;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] a;
      logic [1:0] clr;
      logic [1:0] f;
      logic [1:0] p;
      logic [1:0] s;
   } vec_t;

   vec_t vecs[$];

   c3aibadapt_txasync_filter #(
      .NUM_CH      (NUM_CH),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RST_VAL     (RST_VAL)
   ) dut (
      .osc_clk       (osc_clk),
      .osc_rst       (osc_rst),
      .async_in      (async_in),
      .r_filt_thresh (r_filt_thresh),
      .r_bypass      (r_bypass),
      .sticky_clr    (sticky_clr),
      .filt_out      (filt_out),
      .chg_pulse     (chg_pulse),
      .chg_sticky    (chg_sticky)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic add(input logic [1:0] a, input logic [1:0] clr,
                      input logic [1:0] f, input logic [1:0] p, input logic [1:0] s);
      vec_t v;
      v.a = a; v.clr = clr; v.f = f; v.p = p; v.s = s;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      int pulse_cnt;
      int high_cnt;
      int early;

      // Rising step, T=3: filt_out[0] rises on edge 6, sticky on edge 7
      for (int k = 1; k <= 8; k++)
         add(2'b11, 2'b00, (k >= 6) ? 2'b11 : 2'b10, (k == 6) ? 2'b01 : 2'b00, (k >= 7) ? 2'b01 : 2'b00);
      // Falling step, same latency, sticky stays set
      for (int k = 1; k <= 8; k++)
         add(2'b10, 2'b00, (k >= 6) ? 2'b10 : 2'b11, (k == 6) ? 2'b01 : 2'b00, 2'b01);
      // Clear with no event
      add(2'b10, 2'b01, 2'b10, 2'b00, 2'b00);
      // 3-cycle glitch is rejected
      for (int k = 1; k <= 9; k++)
         add((k <= 3) ? 2'b11 : 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
      // 4-cycle pulse passes: rise at edge 6, fall at edge 10
      for (int k = 1; k <= 11; k++)
         add((k <= 4) ? 2'b11 : 2'b10, 2'b00,
             (k >= 6 && k <= 9) ? 2'b11 : 2'b10,
             (k == 6 || k == 10) ? 2'b01 : 2'b00,
             (k >= 7) ? 2'b01 : 2'b00);

      osc_rst       = 1'b1;
      async_in      = 2'b10;
      r_bypass      = 2'b00;
      sticky_clr    = 2'b00;
      r_filt_thresh = 4'd3;
      repeat (3) step();
      chk("rst filt", int'(filt_out), 2);
      chk("rst pulse", int'(chg_pulse), 0);
      chk("rst sticky", int'(chg_sticky), 0);
      osc_rst = 1'b0;

      // Reset release: no spurious change
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("idle%0d filt", k), int'(filt_out), 2);
         chk($sformatf("idle%0d pulse", k), int'(chg_pulse), 0);
         chk($sformatf("idle%0d sticky", k), int'(chg_sticky), 0);
      end

      foreach (vecs[i]) begin
         async_in   = vecs[i].a;
         sticky_clr = vecs[i].clr;
         step();
         chk($sformatf("vec%0d filt", i), int'(filt_out), int'(vecs[i].f));
         chk($sformatf("vec%0d pulse", i), int'(chg_pulse), int'(vecs[i].p));
         chk($sformatf("vec%0d sticky", i), int'(chg_sticky), int'(vecs[i].s));
      end
      sticky_clr = 2'b00;

      // Clear coinciding with a new pulse: set wins
      async_in = 2'b11;
      found = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (chg_pulse[0]) begin
            found = k;
            break;
         end
      end
      chk("t5 latency", found, 6);
      sticky_clr = 2'b01;
      step();
      chk("t5 set wins sticky", int'(chg_sticky[0]), 1);
      chk("t5 pulse one cycle", int'(chg_pulse[0]), 0);
      step();
      chk("t5 clear", int'(chg_sticky[0]), 0);
      sticky_clr = 2'b00;

      // Bypass on channel 1: park low, clear sticky, then a 1-cycle high pulse
      r_bypass = 2'b10;
      async_in = 2'b01;
      repeat (4) step();
      chk("t4 park filt1", int'(filt_out[1]), 0);
      sticky_clr = 2'b10;
      step();
      sticky_clr = 2'b00;
      chk("t4 park sticky1", int'(chg_sticky[1]), 0);
      async_in = 2'b11;
      step();
      chk("t4 edge1 filt1", int'(filt_out[1]), 0);
      async_in  = 2'b01;
      pulse_cnt = 0;
      high_cnt  = 0;
      for (int k = 2; k <= 8; k++) begin
         step();
         if (k == 3) chk("t4 edge3 filt1", int'(filt_out[1]), 1);
         pulse_cnt += int'(chg_pulse[1]);
         high_cnt  += int'(filt_out[1]);
      end
      chk("t4 pulse count", pulse_cnt, 2);
      chk("t4 high cycles", high_cnt, 1);
      chk("t4 ch0 untouched", int'(filt_out[0]), 1);
      r_bypass = 2'b00;

      // Threshold lowered mid-count commits on the next edge
      r_filt_thresh = 4'd15;
      async_in      = 2'b00;
      early = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (filt_out[0] !== 1'b1) early++;
      end
      chk("t6 hold at T=15", early, 0);
      r_filt_thresh = 4'd2;
      step();
      chk("t6 lowered filt0", int'(filt_out[0]), 0);
      chk("t6 lowered pulse0", int'(chg_pulse[0]), 1);

      // Reset mid-count overrides everything
      r_filt_thresh = 4'd15;
      async_in      = 2'b01;
      repeat (6) step();
      chk("t6 counting filt0", int'(filt_out[0]), 0);
      chk("t6 pre-rst sticky0", int'(chg_sticky[0]), 1);
      osc_rst = 1'b1;
      step();
      chk("t6 rst filt", int'(filt_out), 2);
      chk("t6 rst pulse", int'(chg_pulse), 0);
      chk("t6 rst sticky", int'(chg_sticky), 0);
      osc_rst = 1'b0;
      step();
      chk("t6 post-rst pulse", int'(chg_pulse), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
